// File: rtl/udma_adc_rx_pkg.sv
// Shared types and helpers for the uDMA ADC receive front-end.
// Holds the channel-ID type, FIFO pointer sizing and drop-counter saturation value.
package udma_adc_rx_pkg;

    localparam int CH_ID_T_WIDTH = 4;

    typedef logic [CH_ID_T_WIDTH-1:0] CH_ID_T;

    // One extra pointer bit tells a full FIFO apart from an empty one.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] ovf_sat_value(input int width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/udma_adc_rx_ch_fifo.sv
// Per-channel sample FIFO with flush and sticky overflow flag / saturating drop counter.
// The head entry is presented combinationally; there is no fall-through on an empty FIFO.
module udma_adc_rx_ch_fifo
    import udma_adc_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     flush_i,
    input  logic                     ovf_clr_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     ovf_flag_o,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count_o
);

    localparam int PW = fifo_ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [OVF_CNT_WIDTH-1:0] OVF_SAT = OVF_CNT_WIDTH'(ovf_sat_value(OVF_CNT_WIDTH));

    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic                     ovf_flag_q, ovf_flag_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    logic empty, full, pop, push_ok, ovf_evt;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = ~empty & ready_i;
    assign push_ok = push_i & (~full | pop) & ~flush_i;
    // A flush swallows the push entirely, so it can never count as an overflow.
    assign ovf_evt = push_i & full & ~pop & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Clear is applied first so an overflow in the same cycle survives it.
    always_comb begin
        ovf_flag_d = ovf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (ovf_clr_i) begin
            ovf_flag_d = 1'b0;
            ovf_cnt_d  = '0;
        end
        if (ovf_evt) begin
            ovf_flag_d = 1'b1;
            if (ovf_cnt_d != OVF_SAT) ovf_cnt_d = ovf_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign valid_o     = ~empty;
    assign data_o      = mem_q[rd_ptr_q[AW-1:0]];
    assign ovf_flag_o  = ovf_flag_q;
    assign ovf_count_o = ovf_cnt_q;

endmodule

// File: rtl/udma_adc_rx_mc.sv
// Multi-channel uDMA ADC receive front-end: strobe synchroniser, edge detect,
// sample capture and channel router feeding one FIFO per logical channel.
module udma_adc_rx_mc
    import udma_adc_rx_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 32,
    parameter int ADC_NUM_CHS    = 8,
    parameter int CH_ID_LSB      = 28,
    parameter int CH_ID_WIDTH    = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int OVF_CNT_WIDTH  = 8
) (
    input  logic                                      sys_clk_i,
    input  logic                                      rst_ni,
    input  logic                                      cfg_single_ch_mode_i,
    input  logic [ADC_NUM_CHS-1:0]                    cfg_ch_en_i,
    input  logic [ADC_NUM_CHS-1:0]                    cfg_flush_i,
    input  logic [ADC_NUM_CHS-1:0]                    cfg_ovf_clr_i,
    input  logic                                      adc_rx_valid_async_i,
    input  logic [ADC_DATA_WIDTH-1:0]                 adc_rx_data_i,
    output logic                                      adc_rx_valid_sync_o,
    output logic [ADC_DATA_WIDTH-1:0]                 adc_rx_data_reg_o,
    output logic [ADC_NUM_CHS-1:0][31:0]              data_rx_o,
    output logic [ADC_NUM_CHS-1:0]                    data_rx_valid_o,
    input  logic [ADC_NUM_CHS-1:0]                    data_rx_ready_i,
    output logic [ADC_NUM_CHS-1:0]                    ovf_flag_o,
    output logic [ADC_NUM_CHS-1:0][OVF_CNT_WIDTH-1:0] ovf_count_o
);

    logic [2:0]                sync_q;
    logic                      vsync_q;
    logic [ADC_DATA_WIDTH-1:0] data_reg_q;

    logic                      strobe_edge;
    logic [CH_ID_WIDTH-1:0]    ch_id;
    logic [CH_ID_WIDTH-1:0]    target;
    logic                      force_ch0;
    logic                      target_ok;
    logic [ADC_NUM_CHS-1:0]    push;

    assign strobe_edge = sync_q[1] & ~sync_q[2];

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 3'b000;
            vsync_q    <= 1'b0;
            data_reg_q <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], adc_rx_valid_async_i};
            vsync_q <= strobe_edge;
            if (strobe_edge) data_reg_q <= adc_rx_data_i;
        end
    end

    // Routing looks at the live data bus; it is stable while the edge is detected.
    assign ch_id     = adc_rx_data_i[CH_ID_LSB +: CH_ID_WIDTH];
    assign force_ch0 = cfg_single_ch_mode_i || (ADC_NUM_CHS == 1);
    assign target    = force_ch0 ? '0 : ch_id;
    assign target_ok = force_ch0 || (32'(ch_id) < ADC_NUM_CHS);

    generate
        for (genvar gi = 0; gi < ADC_NUM_CHS; gi++) begin : g_ch
            logic [ADC_DATA_WIDTH-1:0] head;

            assign push[gi] = strobe_edge & target_ok & cfg_ch_en_i[gi]
                            & (target == CH_ID_WIDTH'(gi));

            udma_adc_rx_ch_fifo #(
                .DATA_WIDTH    (ADC_DATA_WIDTH),
                .FIFO_DEPTH    (FIFO_DEPTH),
                .OVF_CNT_WIDTH (OVF_CNT_WIDTH)
            ) u_fifo (
                .clk_i       (sys_clk_i),
                .rst_ni      (rst_ni),
                .push_i      (push[gi]),
                .push_data_i (adc_rx_data_i),
                .flush_i     (cfg_flush_i[gi]),
                .ovf_clr_i   (cfg_ovf_clr_i[gi]),
                .ready_i     (data_rx_ready_i[gi]),
                .valid_o     (data_rx_valid_o[gi]),
                .data_o      (head),
                .ovf_flag_o  (ovf_flag_o[gi]),
                .ovf_count_o (ovf_count_o[gi])
            );

            assign data_rx_o[gi] = 32'(head);
        end
    endgenerate

    assign adc_rx_valid_sync_o = vsync_q;
    assign adc_rx_data_reg_o   = data_reg_q;

endmodule

// File: tb/tb_udma_adc_rx_mc.sv
// Directed plus randomized bench for udma_adc_rx_mc with a queue-based channel model.
module tb_udma_adc_rx_mc;

    localparam int NCH  = 8;
    localparam int DEP  = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                single_mode = 1'b0;
    logic [NCH-1:0]      ch_en = '1;
    logic [NCH-1:0]      flush = '0;
    logic [NCH-1:0]      ovf_clr = '0;
    logic                vasync = 1'b0;
    logic [31:0]         adc_data = '0;
    logic                vsync;
    logic [31:0]         data_reg;
    logic [NCH-1:0][31:0] data_rx;
    logic [NCH-1:0]      rx_valid;
    logic [NCH-1:0]      rx_ready = '0;
    logic [NCH-1:0]      ovf_flag;
    logic [NCH-1:0][CW-1:0] ovf_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [NCH][$];
    bit          m_flag [NCH];
    int          m_cnt  [NCH];

    always #5 clk = ~clk;

    udma_adc_rx_mc #(
        .ADC_DATA_WIDTH (32),
        .ADC_NUM_CHS    (NCH),
        .CH_ID_LSB      (28),
        .CH_ID_WIDTH    (4),
        .FIFO_DEPTH     (DEP),
        .OVF_CNT_WIDTH  (CW)
    ) dut (
        .sys_clk_i            (clk),
        .rst_ni               (rst_n),
        .cfg_single_ch_mode_i (single_mode),
        .cfg_ch_en_i          (ch_en),
        .cfg_flush_i          (flush),
        .cfg_ovf_clr_i        (ovf_clr),
        .adc_rx_valid_async_i (vasync),
        .adc_rx_data_i        (adc_data),
        .adc_rx_valid_sync_o  (vsync),
        .adc_rx_data_reg_o    (data_reg),
        .data_rx_o            (data_rx),
        .data_rx_valid_o      (rx_valid),
        .data_rx_ready_i      (rx_ready),
        .ovf_flag_o           (ovf_flag),
        .ovf_count_o          (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] model_valid();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (mq[c].size() != 0);
        return v;
    endfunction

    task automatic check_all(input string step);
        chk($sformatf("%s valid", step), 32'(rx_valid), 32'(model_valid()));
        for (int c = 0; c < NCH; c++) begin
            if (mq[c].size() != 0) chk($sformatf("%s ch%0d head", step, c), data_rx[c], mq[c][0]);
            chk($sformatf("%s ch%0d flag", step, c), 32'(ovf_flag[c]), 32'(m_flag[c]));
            chk($sformatf("%s ch%0d count", step, c), 32'(ovf_count[c]), 32'(m_cnt[c]));
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_flag[c] = 1'b0;
            m_cnt[c]  = 0;
        end
    endtask

    // Effect of one captured sample together with the ready/flush/clear pulses of that cycle.
    task automatic model_step(input logic [31:0] d, input logic [NCH-1:0] rdy,
                              input logic [NCH-1:0] fl, input logic [NCH-1:0] clr);
        int  id, tgt, pre_size;
        bit  popped [NCH];
        bit  ok;
        id  = int'(d[31:28]);
        tgt = single_mode ? 0 : id;
        ok  = (tgt < NCH) && ch_en[tgt];
        pre_size = (tgt < NCH) ? mq[tgt].size() : 0;
        for (int c = 0; c < NCH; c++) begin
            popped[c] = rdy[c] && (mq[c].size() > 0);
            if (clr[c]) begin
                m_flag[c] = 1'b0;
                m_cnt[c]  = 0;
            end
            if (fl[c]) mq[c].delete();
            else if (popped[c]) void'(mq[c].pop_front());
        end
        if (ok && !fl[tgt]) begin
            if (pre_size == DEP && !popped[tgt]) begin
                m_flag[tgt] = 1'b1;
                if (m_cnt[tgt] < CMAX) m_cnt[tgt]++;
            end else begin
                mq[tgt].push_back(d);
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [NCH-1:0] rdy,
                        input logic [NCH-1:0] fl, input logic [NCH-1:0] clr);
        @(negedge clk);
        adc_data = d;
        vasync   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("latency_pre_valid", 32'(rx_valid), 32'(model_valid()));
        chk("sync_not_early", 32'(vsync), 32'd0);
        rx_ready = rdy;
        flush    = fl;
        ovf_clr  = clr;
        @(negedge clk);
        rx_ready = '0;
        flush    = '0;
        ovf_clr  = '0;
        vasync   = 1'b0;
        model_step(d, rdy, fl, clr);
        chk("sync_pulse", 32'(vsync), 32'd1);
        chk("data_reg", data_reg, d);
        $display("send data=%h rdy=%h flush=%h clr=%h valid=%h", d, rdy, fl, clr, rx_valid);
        @(negedge clk);
        chk("sync_one_cycle", 32'(vsync), 32'd0);
        @(negedge clk);
    endtask

    task automatic pop_ch(input int c);
        @(negedge clk);
        rx_ready[c] = 1'b1;
        @(negedge clk);
        rx_ready = '0;
        if (mq[c].size() > 0) void'(mq[c].pop_front());
        $display("pop ch%0d valid=%h", c, rx_valid);
    endtask

    task automatic flush_ch(input int c);
        @(negedge clk);
        flush[c] = 1'b1;
        @(negedge clk);
        flush = '0;
        mq[c].delete();
        $display("flush ch%0d valid=%h", c, rx_valid);
    endtask

    initial begin
        logic [31:0] d;
        logic [NCH-1:0] rdy, fl, clr;
        int r;

        model_clear();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_sync", 32'(vsync), 32'd0);
        chk("reset_data_reg", data_reg, 32'd0);
        chk("reset_data_rx3", data_rx[3], 32'd0);
        chk("reset_flags", 32'(ovf_flag), 32'd0);
        chk("reset_counts", 32'(ovf_count), 32'd0);
        rst_n = 1'b1;

        // Basic single strobe to channel 3, then pop it.
        send(32'h3000_00AB, '0, '0, '0);
        check_all("t1");
        chk("t1_ch3_data", data_rx[3], 32'h3000_00AB);
        pop_ch(3);
        check_all("t1_pop");

        // Single-channel mode forces everything into channel 0.
        single_mode = 1'b1;
        send(32'h5000_0001, '0, '0, '0);
        send(32'h2000_0002, '0, '0, '0);
        send(32'h7000_0003, '0, '0, '0);
        check_all("t2");
        for (int k = 0; k < 3; k++) begin
            pop_ch(0);
            check_all("t2_drain");
        end
        single_mode = 1'b0;

        // Overflow on ch1 and in-order drain.
        for (int k = 0; k < 6; k++) send(32'h1000_0010 + 32'(k), '0, '0, '0);
        check_all("t3");
        chk("t3_count", 32'(ovf_count[1]), 32'd2);
        for (int k = 0; k < 4; k++) begin
            pop_ch(1);
            check_all("t3_drain");
        end

        // Counter saturation, then clear coinciding with an overflow.
        for (int k = 0; k < 7; k++) send(32'h1000_0100 + 32'(k), '0, '0, '0);
        check_all("t4_sat");
        chk("t4_sat_count", 32'(ovf_count[1]), 32'd3);
        send(32'h1000_0200, '0, '0, 8'h02);
        check_all("t4_clr");
        chk("t4_clr_count", 32'(ovf_count[1]), 32'd1);
        flush_ch(1);
        check_all("t4_flush");

        // Out-of-range ID and a disabled channel are dropped silently.
        send(32'h9000_0009, '0, '0, '0);
        ch_en[4] = 1'b0;
        send(32'h4000_0004, '0, '0, '0);
        ch_en[4] = 1'b1;
        check_all("t5");

        // Full ch2 with a same-cycle pop, then flush during a push.
        for (int k = 0; k < 4; k++) send(32'h2000_0020 + 32'(k), '0, '0, '0);
        send(32'h2000_0030, 8'h04, '0, '0);
        check_all("t6_full_pop");
        send(32'h2000_0031, '0, 8'h04, '0);
        check_all("t6_flush_push");

        // Randomized mix of samples, pops and flushes.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                ch_en       = 8'($urandom) | 8'($urandom);
                single_mode = ($urandom_range(0, 4) == 0);
                d   = {4'($urandom_range(0, 15)), 28'($urandom)};
                rdy = 8'($urandom) & 8'($urandom);
                fl  = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                clr = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                send(d, rdy, fl, clr);
            end else if (r < 9) begin
                pop_ch($urandom_range(0, NCH - 1));
            end else begin
                flush_ch($urandom_range(0, NCH - 1));
            end
            check_all($sformatf("rand%0d", it));
        end
        single_mode = 1'b0;
        ch_en = '1;

        // Asynchronous reset in the middle of activity.
        send(32'h6000_0066, '0, '0, '0);
        send(32'h0000_0077, '0, '0, '0);
        @(negedge clk);
        vasync = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rx_valid), 32'd0);
        chk("async_rst_flags", 32'(ovf_flag), 32'd0);
        chk("async_rst_data_reg", data_reg, 32'd0);
        @(negedge clk);
        vasync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check_all("post_reset");
        send(32'h5000_0055, '0, '0, '0);
        check_all("post_reset_send");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
